proj_sweep_engine: RTL

Self-checking stimulus/response stage wrapped around a combinational projection circuit (17 inputs x0..x16, one output y0). It drives the projection's input vector from an exhaustive counter or a 17-bit LFSR, samples the returned y0, and accumulates an onset count and a 16-bit MISR signature. Comparing these against the golden values for the unoptimised function validates each D-reduced netlist in simulation or on FPGA.

---
 rtl/proj_sweep_pkg.sv | 10 +
 rtl/proj_misr.sv | 19 +
 rtl/proj_sweep_engine.sv | 108 ++++++++++
 3 files changed

// File: rtl/proj_sweep_pkg.sv
// proj_sweep_pkg: shared types and constants for the projection sweep engine
// Contents: FSM state enum, LFSR tap positions, MISR polynomial, mode encodings.
package proj_sweep_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int LFSR_A = 17;
    localparam int LFSR_B = 14;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic MODE_EXH  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;
endpackage

// File: rtl/proj_misr.sv
// proj_misr: serial MISR compacting one response bit per enabled cycle
// Ports: clk, rst (sync, active-high), clr (zero the state), en (absorb d), d (response bit), sig (MISR state).
module proj_misr
    import proj_sweep_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] sig
);
    always_ff @(posedge clk) begin
        if (rst || clr) sig <= '0;
        else if (en) sig <= {sig[W-2:0], 1'b0} ^ ((sig[W-1] ^ d) ? W'(MISR_POLY) : '0);
    end
endmodule

// File: rtl/proj_sweep_engine.sv
// proj_sweep_engine: drives a projection circuit with exhaustive/LFSR vectors and compacts its y0 response
// Ports: clk, rst (sync, active-high); start/mode/seed/num_vec configure a sweep;
//        x/x_valid drive the projection, y0 returns from it; busy/done report progress;
//        onset_cnt counts sampled ones, signature is the MISR state.
module proj_sweep_engine
    import proj_sweep_pkg::*;
#(
    parameter int N_IN  = 17,
    parameter int CNT_W = N_IN + 1,
    parameter int SIG_W = 16,
    parameter int Y_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N_IN-1:0]  seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [N_IN-1:0]  x,
    output logic             x_valid,
    input  logic             y0,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [SIG_W-1:0] signature
);
    state_t state, state_n;
    logic md, fb, accept, zero, x_last, q, ql, fin;
    logic [CNT_W-1:0] rem;
    // vv/lv: valid and last-vector flags delayed by 0..Y_LAT cycles; the top bit qualifies y0
    logic [Y_LAT:0] vv, lv;
    assign vv[0] = x_valid;
    assign lv[0] = x_last;
    if (Y_LAT > 0) begin : g_pipe
        logic [Y_LAT-1:0] vr, lr;
        always_ff @(posedge clk) begin
            if (rst) begin
                vr <= '0;
                lr <= '0;
            end else begin
                vr <= vv[Y_LAT-1:0];
                lr <= lv[Y_LAT-1:0];
            end
        end
        assign vv[Y_LAT:1] = vr;
        assign lv[Y_LAT:1] = lr;
    end
    // x^17+x^14+1 feedback; narrow builds fall back to a plain rotate of the top bit
    if (N_IN >= LFSR_A) begin : g_fb
        assign fb = x[LFSR_A-1] ^ x[LFSR_B-1];
    end else begin : g_fb_s
        assign fb = x[N_IN-1];
    end
    always_comb begin
        accept  = (state == IDLE || state == DONE) && start;
        zero    = mode == MODE_LFSR && num_vec == '0;
        x_last  = x_valid && rem == CNT_W'(1);
        q       = vv[Y_LAT];
        ql      = lv[Y_LAT];
        busy    = state == RUN || state == DRAIN;
        fin     = (accept && zero) || (busy && ql);
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? (zero ? DONE : RUN) : state;
            RUN:        state_n = ql ? DONE : (x_last ? DRAIN : RUN);
            DRAIN:      state_n = ql ? DONE : DRAIN;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            md        <= MODE_EXH;
            x         <= '0;
            x_valid   <= 1'b0;
            rem       <= '0;
            onset_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                md        <= mode;
                x         <= mode == MODE_LFSR ? (seed == '0 ? N_IN'(1) : seed) : '0;
                x_valid   <= !zero;
                rem       <= mode == MODE_LFSR ? num_vec : CNT_W'(1) << N_IN;
                onset_cnt <= '0;
            end else begin
                if (x_valid) begin
                    x   <= md == MODE_LFSR ? {x[N_IN-2:0], fb} : x + N_IN'(1);
                    rem <= rem - CNT_W'(1);
                    if (x_last) x_valid <= 1'b0;
                end
                if (q) onset_cnt <= onset_cnt + CNT_W'(y0);
            end
        end
    end
    proj_misr #(.W(SIG_W)) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (q && !accept),
        .d   (y0),
        .sig (signature)
    );
endmodule
